fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction fetch buffer between the fetch stage (program counter plus instruction memory) and the decode stage of the RV32i pipeline. It accepts one {PC, instruction} pair per cycle from fetch, queues up to DEPTH pairs, and presents the oldest pair to decode in first-word-fall-through order. It back-pressures the program counter through F_Ready, which drives PC_En. On a taken branch or jump it discards every queued and incoming instruction.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- NOP_INSTR, 32'h0000_0013 (ADDI x0,x0,0), instruction presented when empty

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge
- RST_N  in  1  reset, asynchronous, active-low
- Flush  in  1  taken branch/jump redirect from execute; discards all contents
- F_Valid  in  1  fetch presents a valid instruction this cycle
- F_PC  in  32  PC of the presented instruction
- F_Instr  in  32  instruction word from instruction memory
- F_Ready  out  1  buffer can accept a push; drives PC_En
- D_Valid  out  1  head entry is valid
- D_PC  out  32  PC of the head entry
- D_Instr  out  32  instruction of the head entry
- D_Ready  in  1  decode consumes the head this cycle (decode not stalled)
- Count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH

## Operation
- Storage: circular array of DEPTH entries, with a write pointer and a read pointer, each $clog2(DEPTH) bits wide and wrapping DEPTH-1 to 0. A separate count register ranges 0..DEPTH.
- push = F_Valid && F_Ready && !Flush; pop = D_Valid && D_Ready && !Flush.
- Push: write {F_PC, F_Instr} at the write pointer, then increment the write pointer.
- Pop: increment the read pointer.
- Count update: count + push - pop. Push and pop in the same cycle leave count unchanged; this is legal at any occupancy from 1 to DEPTH-1.
- Full (Count == DEPTH): F_Ready = 0, so pushes are refused. A pop in the same cycle is still performed. F_Ready is decoded from registered count only and has no combinational path from D_Ready.
- Empty (Count == 0): D_Valid = 0, D_PC = 32'h0, D_Instr = NOP_INSTR, and D_Ready is ignored. A push in the same cycle is performed.
- Flush: on the next edge both pointers and count go to 0. Any push or pop in the flush cycle is discarded. Stored data is not cleared.
- Reset: asynchronous. Pointers and count go to 0; storage contents are don't-care.
- Reset values of outputs: F_Ready = 1, D_Valid = 0, D_PC = 0, D_Instr = NOP_INSTR, Count = 0.

## Timing
- Push latency is 1 cycle: an entry pushed into an empty buffer at edge N appears on D_* and raises D_Valid immediately after edge N.
- D_* are combinational reads of the head entry, gated by the registered empty flag. There is no bypass from F_* to D_*, so minimum fetch-to-decode latency is one edge.
- F_Ready falls immediately after the edge at which Count reaches DEPTH. It rises immediately after the first edge with a pop.
- Throughput is one push and one pop per cycle when not full or empty.
- Flush asserted in cycle N: after edge N, D_Valid = 0 and Count = 0. The first post-redirect push is accepted at edge N+1.
- RST_N deassertion is synchronised externally. The first push can occur at the first edge after deassertion.

## Structure
- The shared definitions package gains:
  - NOP_INSTR constant
  - FETCH_BUF_DEPTH constant, default 4
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}
- The existing CLOCK_PERIOD constant is reused by the bench.
- Single module with no sub-module; the storage is an array of fetch_entry_t.

## Test plan
- Fill: reset, F_Valid = 1, PCs 0x00/0x04/0x08/0x0C, D_Ready = 0. Count steps 1..4; F_Ready = 0 after the 4th edge; a 5th push at PC 0x10 is refused and Count stays 4.
- Drain: from full, F_Valid = 0, D_Ready = 1. D_PC reads 0x00, 0x04, 0x08, 0x0C on consecutive cycles; then D_Valid = 0 and D_Instr = 32'h13.
- Streaming with wrap-around: F_Valid = D_Ready = 1 for 12 cycles, PCs 0x00..0x2C. Count holds at 1 and every PC appears on D_PC exactly once, in order, one cycle after its push.
- Flush: with 3 entries queued, assert Flush together with a push at PC 0x40. Next cycle Count = 0 and D_Valid = 0. A push at PC 0x80 appears on D_PC the following cycle.
- Full plus simultaneous pop: at Count = 4, F_Valid = 1, D_Ready = 1. The pop occurs, the push is refused, Count = 3 and F_Ready = 1 on the next cycle.
- Asynchronous reset mid-stream: pull RST_N low between edges with 2 entries queued. Count = 0, D_Valid = 0 and F_Ready = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the fetch/decode boundary of the RV32i pipeline.
package fetch_buffer_pkg;

  localparam int CLOCK_PERIOD = 10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int FETCH_BUF_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// First-word-fall-through queue of {PC, instruction} pairs between fetch and decode.
// Handshake: a transfer happens on an edge where valid and ready are both high and Flush is low.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH,
  parameter logic [31:0] NOP_INSTR = fetch_buffer_pkg::NOP_INSTR
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       Flush,
  input  logic                       F_Valid,
  input  logic [31:0]                F_PC,
  input  logic [31:0]                F_Instr,
  output logic                       F_Ready,
  output logic                       D_Valid,
  output logic [31:0]                D_PC,
  output logic [31:0]                D_Instr,
  input  logic                       D_Ready,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Status comes from the registered count only, so F_Ready never depends on D_Ready.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign F_Ready = !full;
  assign D_Valid = !empty;
  assign Count   = count;

  assign push = F_Valid && F_Ready && !Flush;
  assign pop  = D_Valid && D_Ready && !Flush;

  assign D_PC    = empty ? 32'h0 : mem[rd_ptr].pc;
  assign D_Instr = empty ? NOP_INSTR : mem[rd_ptr].instr;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: F_PC, instr: F_Instr};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: fill, drain, streaming wrap, flush, full+pop, async reset.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        f_valid = 1'b0;
  logic [31:0] f_pc = '0;
  logic [31:0] f_instr = '0;
  logic        f_ready;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_ready = 1'b0;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  always #(CLOCK_PERIOD / 2) clk = ~clk;

  fetch_buffer dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .Flush   (flush),
    .F_Valid (f_valid),
    .F_PC    (f_pc),
    .F_Instr (f_instr),
    .F_Ready (f_ready),
    .D_Valid (d_valid),
    .D_PC    (d_pc),
    .D_Instr (d_instr),
    .D_Ready (d_ready),
    .Count   (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] pc);
    f_valid = v;
    f_pc    = pc;
    f_instr = 32'hA000_0000 | pc;
  endtask

  initial begin
    // Reset values while held in reset
    #(2 * CLOCK_PERIOD + 1);
    check("rst_f_ready", 32'(f_ready), 32'd1);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_pc", d_pc, 32'h0);
    check("rst_d_instr", d_instr, 32'h13);
    check("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 32'(i * 4));
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
    end
    check("fill_f_ready", 32'(f_ready), 32'd0);
    set_fetch(1'b1, 32'h10);
    tick();
    check("fill_refused_count", 32'(count), 32'd4);
    check("fill_head_pc", d_pc, 32'h0);

    // Drain
    set_fetch(1'b0, 32'h0);
    d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", d_pc, 32'(i * 4));
      check("drain_instr", d_instr, 32'hA000_0000 | 32'(i * 4));
      tick();
      if (i == 0) check("drain_f_ready", 32'(f_ready), 32'd1);
    end
    check("drain_d_valid", 32'(d_valid), 32'd0);
    check("drain_nop", d_instr, 32'h13);
    check("drain_count", 32'(count), 32'd0);

    // Streaming with wrap-around
    for (int i = 0; i < 12; i++) begin
      set_fetch(1'b1, 32'(i * 4));
      exp_q.push_back(32'(i * 4));
      tick();
      check("stream_count", 32'(count), 32'd1);
      check("stream_pc", d_pc, exp_q.pop_front());
    end
    set_fetch(1'b0, 32'h0);
    tick();
    check("stream_empty", 32'(count), 32'd0);

    // Flush
    d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_fetch(1'b1, 32'h100 + 32'(i * 4));
      tick();
    end
    check("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    d_ready = 1'b1;
    set_fetch(1'b1, 32'h40);
    tick();
    check("flush_count", 32'(count), 32'd0);
    check("flush_d_valid", 32'(d_valid), 32'd0);
    flush = 1'b0;
    d_ready = 1'b0;
    set_fetch(1'b1, 32'h80);
    tick();
    check("post_flush_pc", d_pc, 32'h80);
    check("post_flush_count", 32'(count), 32'd1);
    set_fetch(1'b0, 32'h0);
    d_ready = 1'b1;
    tick();
    check("post_flush_drain", 32'(d_valid), 32'd0);

    // Full plus simultaneous pop
    d_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 32'h200 + 32'(i * 4));
      tick();
    end
    check("full_count", 32'(count), 32'd4);
    set_fetch(1'b1, 32'h210);
    d_ready = 1'b1;
    tick();
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_f_ready", 32'(f_ready), 32'd1);
    check("fullpop_head", d_pc, 32'h204);
    set_fetch(1'b0, 32'h0);
    tick();
    check("fullpop_head2", d_pc, 32'h208);
    tick();
    check("fullpop_head3", d_pc, 32'h20C);
    tick();
    check("fullpop_refused", 32'(d_valid), 32'd0);

    // Asynchronous reset mid-stream
    d_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_fetch(1'b1, 32'h300 + 32'(i * 4));
      tick();
    end
    set_fetch(1'b0, 32'h0);
    check("pre_arst_count", 32'(count), 32'd2);
    #(CLOCK_PERIOD / 4);
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_d_valid", 32'(d_valid), 32'd0);
    check("arst_f_ready", 32'(f_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
